// File: rtl/grid_display_pkg.sv
// rtl/grid_display_pkg.sv - shared constants and helpers for the grid display renderer
//
// Purpose : default 800x600 timing, segment-boundary constants, palette
//           constants and a counter-width helper used by the renderer.
// Ports   : none (package).
package grid_display_pkg;

   // Horizontal segments in pixels: sync, back porch, active, front porch.
   localparam int H_SYNC_D   = 120;
   localparam int H_BP_D     = 64;
   localparam int H_ACTIVE_D = 800;
   localparam int H_FP_D     = 56;
   localparam int H_TOTAL_D  = H_SYNC_D + H_BP_D + H_ACTIVE_D + H_FP_D;

   // Vertical segments in lines.
   localparam int V_SYNC_D   = 6;
   localparam int V_BP_D     = 23;
   localparam int V_ACTIVE_D = 600;
   localparam int V_FP_D     = 37;
   localparam int V_TOTAL_D  = V_SYNC_D + V_BP_D + V_ACTIVE_D + V_FP_D;

   // Segment boundaries of the default timing (first index of each segment).
   localparam int H_ACT_START_D = H_SYNC_D + H_BP_D;
   localparam int H_FP_START_D  = H_ACT_START_D + H_ACTIVE_D;
   localparam int V_ACT_START_D = V_SYNC_D + V_BP_D;
   localparam int V_FP_START_D  = V_ACT_START_D + V_ACTIVE_D;

   // RGB 1-1-1 palette.
   localparam logic [2:0] COLOR_RED       = 3'b100;
   localparam logic [2:0] COLOR_GREEN     = 3'b010;
   localparam logic [2:0] COLOR_BLUE      = 3'b001;
   localparam logic [2:0] COLOR_BLACK     = 3'b000;
   localparam logic [2:0] GRID_LINE_COLOR = 3'b111;

   // Bits needed to count 0..n-1 (at least one bit).
   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/grid_display_ctrl_if.sv
// rtl/grid_display_ctrl_if.sv - grid bus and video outputs of the grid display renderer
//
// Purpose : bundles the flat grid input with the video/tick outputs.
// Signals : grid_data  - flat grid, column c at [c*NUM_ROWS*COLOR_W +: NUM_ROWS*COLOR_W],
//                        row r in slot NUM_ROWS-1-r of its column
//           frame_tick - one-clock pulse at start of vertical front porch
//           hsync/vsync, vga_rgb - video outputs
// Modports: master = game side, slave = renderer.
interface grid_display_ctrl_if #(
   parameter int NUM_COLS = 4,
   parameter int NUM_ROWS = 8,
   parameter int COLOR_W  = 3
);
   logic [NUM_COLS*NUM_ROWS*COLOR_W-1:0] grid_data;
   logic                                 frame_tick;
   logic                                 hsync;
   logic                                 vsync;
   logic [COLOR_W-1:0]                   vga_rgb;

   modport master (
      output grid_data,
      input  frame_tick, hsync, vsync, vga_rgb
   );

   modport slave (
      input  grid_data,
      output frame_tick, hsync, vsync, vga_rgb
   );
endinterface

// File: rtl/grid_display_ctrl_timing.sv
// rtl/grid_display_ctrl_timing.sv - pixel-enable divider, raster counters and sync decode
//
// Purpose : free-running pixel enable, x/y raster counters, raw sync levels,
//           active-area flags, line/frame strobes and the frame tick.
// Ports   : i_clk, i_rst          - clock, async active-high reset
//           o_pe                  - pixel enable
//           o_x_wrap              - pe on the last pixel of a line
//           o_h_act, o_h_act_last - x inside active area / on its last pixel
//           o_v_act, o_v_act_last - y inside active area / on its last line
//           o_pre_act_line        - y on the line just before active area
//           o_hsync_raw, o_vsync_raw - undelayed sync levels
//           o_frame_tick          - pe at x=0 of the first front-porch line
module vga_timing_gen
   import grid_display_pkg::*;
#(
   parameter int PIX_DIV  = 1,
   parameter int H_SYNC   = H_SYNC_D,
   parameter int H_BP     = H_BP_D,
   parameter int H_ACTIVE = H_ACTIVE_D,
   parameter int H_FP     = H_FP_D,
   parameter int V_SYNC   = V_SYNC_D,
   parameter int V_BP     = V_BP_D,
   parameter int V_ACTIVE = V_ACTIVE_D,
   parameter int V_FP     = V_FP_D,
   parameter bit SYNC_POL = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst,
   output logic o_pe,
   output logic o_x_wrap,
   output logic o_h_act,
   output logic o_h_act_last,
   output logic o_v_act,
   output logic o_v_act_last,
   output logic o_pre_act_line,
   output logic o_hsync_raw,
   output logic o_vsync_raw,
   output logic o_frame_tick
);

   localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
   localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
   localparam int XW      = cnt_width(H_TOTAL);
   localparam int YW      = cnt_width(V_TOTAL);
   localparam int DW      = cnt_width(PIX_DIV);

   localparam logic [DW-1:0] D_LAST      = DW'(PIX_DIV - 1);
   localparam logic [XW-1:0] X_LAST      = XW'(H_TOTAL - 1);
   localparam logic [XW-1:0] X_SYNC_END  = XW'(H_SYNC);
   localparam logic [XW-1:0] X_ACT_START = XW'(H_SYNC + H_BP);
   localparam logic [XW-1:0] X_ACT_END   = XW'(H_SYNC + H_BP + H_ACTIVE);
   localparam logic [XW-1:0] X_ACT_LAST  = XW'(H_SYNC + H_BP + H_ACTIVE - 1);
   localparam logic [YW-1:0] Y_LAST      = YW'(V_TOTAL - 1);
   localparam logic [YW-1:0] Y_SYNC_END  = YW'(V_SYNC);
   localparam logic [YW-1:0] Y_PRE_ACT   = YW'(V_SYNC + V_BP - 1);
   localparam logic [YW-1:0] Y_ACT_START = YW'(V_SYNC + V_BP);
   localparam logic [YW-1:0] Y_ACT_END   = YW'(V_SYNC + V_BP + V_ACTIVE);
   localparam logic [YW-1:0] Y_ACT_LAST  = YW'(V_SYNC + V_BP + V_ACTIVE - 1);

   logic [DW-1:0] r_div;
   logic [XW-1:0] r_x_cnt;
   logic [YW-1:0] r_y_cnt;
   logic          w_pe;

   assign w_pe = (r_div == '0);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_div   <= '0;
         r_x_cnt <= '0;
         r_y_cnt <= '0;
      end else begin
         r_div <= (r_div == D_LAST) ? '0 : r_div + DW'(1);
         if (w_pe) begin
            if (r_x_cnt == X_LAST) begin
               r_x_cnt <= '0;
               r_y_cnt <= (r_y_cnt == Y_LAST) ? '0 : r_y_cnt + YW'(1);
            end else begin
               r_x_cnt <= r_x_cnt + XW'(1);
            end
         end
      end
   end

   assign o_pe           = w_pe;
   assign o_x_wrap       = w_pe && (r_x_cnt == X_LAST);
   assign o_h_act        = (r_x_cnt >= X_ACT_START) && (r_x_cnt < X_ACT_END);
   assign o_h_act_last   = (r_x_cnt == X_ACT_LAST);
   assign o_v_act        = (r_y_cnt >= Y_ACT_START) && (r_y_cnt < Y_ACT_END);
   assign o_v_act_last   = (r_y_cnt == Y_ACT_LAST);
   assign o_pre_act_line = (r_y_cnt == Y_PRE_ACT);
   assign o_hsync_raw    = (r_x_cnt < X_SYNC_END) ? SYNC_POL : ~SYNC_POL;
   assign o_vsync_raw    = (r_y_cnt < Y_SYNC_END) ? SYNC_POL : ~SYNC_POL;
   assign o_frame_tick   = w_pe && (r_x_cnt == '0) && (r_y_cnt == Y_ACT_END);

endmodule

// File: rtl/grid_display_ctrl.sv
// rtl/grid_display_ctrl.sv - VGA renderer painting a grid of solid colour cells
//
// Purpose : snapshots the grid once per frame (just before the first active
//           line) and paints NUM_COLS x NUM_ROWS cells through a 2-stage
//           pixel pipeline with hsync/vsync aligned to colour.
// Ports   : CLK_50M - system clock
//           RST     - asynchronous active-high reset
//           bus     - grid_display_ctrl_if.slave (grid_data in; frame_tick,
//                     hsync, vsync, vga_rgb out)
// Options : define GRID_LINES_EN to draw GRID_LINE_COLOR on the first pixel
//           column and first line of every cell.
module grid_display_ctrl
   import grid_display_pkg::*;
#(
   parameter int NUM_COLS = 4,
   parameter int NUM_ROWS = 8,
   parameter int COLOR_W  = 3,
   parameter int PIX_DIV  = 1,
   parameter int H_SYNC   = H_SYNC_D,
   parameter int H_BP     = H_BP_D,
   parameter int H_ACTIVE = H_ACTIVE_D,
   parameter int H_FP     = H_FP_D,
   parameter int V_SYNC   = V_SYNC_D,
   parameter int V_BP     = V_BP_D,
   parameter int V_ACTIVE = V_ACTIVE_D,
   parameter int V_FP     = V_FP_D,
   parameter bit SYNC_POL = 1'b0
) (
   input  logic              CLK_50M,
   input  logic              RST,
   grid_display_ctrl_if.slave bus
);

   localparam int CELL_W = H_ACTIVE / NUM_COLS;
   localparam int CELL_H = V_ACTIVE / NUM_ROWS;
   localparam int PXW    = cnt_width(CELL_W);
   localparam int LNW    = cnt_width(CELL_H);
   localparam int CW     = cnt_width(NUM_COLS);
   localparam int RW     = cnt_width(NUM_ROWS);

   localparam logic [PXW-1:0] PX_LAST = PXW'(CELL_W - 1);
   localparam logic [LNW-1:0] LN_LAST = LNW'(CELL_H - 1);

   logic w_pe, w_x_wrap, w_h_act, w_h_act_last, w_v_act, w_v_act_last;
   logic w_pre_act_line, w_hsync_raw, w_vsync_raw, w_frame_tick;

   vga_timing_gen #(
      .PIX_DIV  (PIX_DIV),
      .H_SYNC   (H_SYNC),
      .H_BP     (H_BP),
      .H_ACTIVE (H_ACTIVE),
      .H_FP     (H_FP),
      .V_SYNC   (V_SYNC),
      .V_BP     (V_BP),
      .V_ACTIVE (V_ACTIVE),
      .V_FP     (V_FP),
      .SYNC_POL (SYNC_POL)
   ) u_timing (
      .i_clk          (CLK_50M),
      .i_rst          (RST),
      .o_pe           (w_pe),
      .o_x_wrap       (w_x_wrap),
      .o_h_act        (w_h_act),
      .o_h_act_last   (w_h_act_last),
      .o_v_act        (w_v_act),
      .o_v_act_last   (w_v_act_last),
      .o_pre_act_line (w_pre_act_line),
      .o_hsync_raw    (w_hsync_raw),
      .o_vsync_raw    (w_vsync_raw),
      .o_frame_tick   (w_frame_tick)
   );

   // Cell counters describe the pixel the raster counters currently point at.
   // They clear on the last active pixel/line instead of advancing, so the
   // column and row indices can never step past the last cell.
   logic [PXW-1:0] r_cell_px;
   logic [LNW-1:0] r_cell_ln;
   logic [CW-1:0]  r_col_idx;
   logic [RW-1:0]  r_row_idx;

   always_ff @(posedge CLK_50M or posedge RST) begin
      if (RST) begin
         r_cell_px <= '0;
         r_col_idx <= '0;
         r_cell_ln <= '0;
         r_row_idx <= '0;
      end else if (w_pe) begin
         if (w_h_act && !w_h_act_last) begin
            if (r_cell_px == PX_LAST) begin
               r_cell_px <= '0;
               r_col_idx <= r_col_idx + CW'(1);
            end else begin
               r_cell_px <= r_cell_px + PXW'(1);
            end
         end else begin
            r_cell_px <= '0;
            r_col_idx <= '0;
         end

         if (w_x_wrap) begin
            if (w_v_act && !w_v_act_last) begin
               if (r_cell_ln == LN_LAST) begin
                  r_cell_ln <= '0;
                  r_row_idx <= r_row_idx + RW'(1);
               end else begin
                  r_cell_ln <= r_cell_ln + LNW'(1);
               end
            end else begin
               r_cell_ln <= '0;
               r_row_idx <= '0;
            end
         end
      end
   end

   // Shadow grid: loaded only at the end of the last line before the active
   // area so a frame always shows one consistent grid.
   logic [COLOR_W-1:0] r_shadow [NUM_COLS][NUM_ROWS];

   always_ff @(posedge CLK_50M or posedge RST) begin
      if (RST) begin
         for (int c = 0; c < NUM_COLS; c++) begin
            for (int r = 0; r < NUM_ROWS; r++) begin
               r_shadow[c][r] <= '0;
            end
         end
      end else if (w_x_wrap && w_pre_act_line) begin
         for (int c = 0; c < NUM_COLS; c++) begin
            for (int r = 0; r < NUM_ROWS; r++) begin
               r_shadow[c][r] <= bus.grid_data[(c*NUM_ROWS + NUM_ROWS-1-r)*COLOR_W +: COLOR_W];
            end
         end
      end
   end

   // Two-stage pixel pipeline; syncs travel alongside so all outputs align.
   logic [CW-1:0]      r_s1_col;
   logic [RW-1:0]      r_s1_row;
   logic               r_s1_act;
   logic               r_s1_hsync;
   logic               r_s1_vsync;
   logic [COLOR_W-1:0] r_rgb;
   logic               r_hsync;
   logic               r_vsync;
`ifdef GRID_LINES_EN
   logic               r_s1_line;
`endif

   always_ff @(posedge CLK_50M or posedge RST) begin
      if (RST) begin
         r_s1_col   <= '0;
         r_s1_row   <= '0;
         r_s1_act   <= 1'b0;
         r_s1_hsync <= ~SYNC_POL;
         r_s1_vsync <= ~SYNC_POL;
         r_rgb      <= '0;
         r_hsync    <= ~SYNC_POL;
         r_vsync    <= ~SYNC_POL;
`ifdef GRID_LINES_EN
         r_s1_line  <= 1'b0;
`endif
      end else if (w_pe) begin
         r_s1_col   <= r_col_idx;
         r_s1_row   <= r_row_idx;
         r_s1_act   <= w_h_act && w_v_act;
         r_s1_hsync <= w_hsync_raw;
         r_s1_vsync <= w_vsync_raw;
         r_hsync    <= r_s1_hsync;
         r_vsync    <= r_s1_vsync;
`ifdef GRID_LINES_EN
         r_s1_line  <= (r_cell_px == '0) || (r_cell_ln == '0);
         if (!r_s1_act)
            r_rgb <= '0;
         else if (r_s1_line)
            r_rgb <= COLOR_W'(GRID_LINE_COLOR);
         else
            r_rgb <= r_shadow[r_s1_col][r_s1_row];
`else
         r_rgb      <= r_s1_act ? r_shadow[r_s1_col][r_s1_row] : '0;
`endif
      end
   end

   assign bus.vga_rgb    = r_rgb;
   assign bus.hsync      = r_hsync;
   assign bus.vsync      = r_vsync;
   assign bus.frame_tick = w_frame_tick;

endmodule

// File: tb/tb_grid_display_ctrl.sv
// tb/tb_grid_display_ctrl.sv - directed self-checking bench for grid_display_ctrl
module tb_grid_display_ctrl;

   // Reduced timing: H 4/3/16/5 = 28, V 2/2/16/3 = 23, cells 4 px x 2 lines.
   // Active x 7..22, active y 4..19, snapshot at x=27 y=3, tick at x=0 y=20.
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;
   int   n     = 0;
   logic [95:0] g;

   always #5 clk = ~clk;

   grid_display_ctrl_if #(.NUM_COLS(4), .NUM_ROWS(8), .COLOR_W(3)) bus1 ();
   grid_display_ctrl_if #(.NUM_COLS(4), .NUM_ROWS(8), .COLOR_W(3)) bus2 ();

   grid_display_ctrl #(
      .NUM_COLS(4), .NUM_ROWS(8), .COLOR_W(3), .PIX_DIV(1),
      .H_SYNC(4), .H_BP(3), .H_ACTIVE(16), .H_FP(5),
      .V_SYNC(2), .V_BP(2), .V_ACTIVE(16), .V_FP(3),
      .SYNC_POL(1'b0)
   ) dut1 (
      .CLK_50M (clk),
      .RST     (rst),
      .bus     (bus1)
   );

   grid_display_ctrl #(
      .NUM_COLS(4), .NUM_ROWS(8), .COLOR_W(3), .PIX_DIV(2),
      .H_SYNC(4), .H_BP(3), .H_ACTIVE(16), .H_FP(5),
      .V_SYNC(2), .V_BP(2), .V_ACTIVE(16), .V_FP(3),
      .SYNC_POL(1'b0)
   ) dut2 (
      .CLK_50M (clk),
      .RST     (rst),
      .bus     (bus2)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to n clock edges after reset release, then sample 1 time unit later.
   task automatic adv(input int target);
      while (n < target) begin
         @(posedge clk);
         n++;
      end
      #1;
   endtask

   initial begin
      g = '0;
      bus1.grid_data = '0;
      bus2.grid_data = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_hsync", 32'(bus1.hsync), 32'd1);
      check("rst_vsync", 32'(bus1.vsync), 32'd1);
      check("rst_rgb", 32'(bus1.vga_rgb), 32'd0);
      check("rst_tick", 32'(bus1.frame_tick), 32'd0);
      check("rst_hsync2", 32'(bus2.hsync), 32'd1);

      // Column c painted colour c+1 in every row.
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 8; r++)
            g[(c*8 + 7 - r)*3 +: 3] = 3'(c + 1);
      bus1.grid_data = g;
      rst = 1'b0;
      n = 0;

      adv(1);   check("hs_pipe_reset", 32'(bus1.hsync), 32'd1);
                check("hs2_n1", 32'(bus2.hsync), 32'd1);
      adv(2);   check("hs_first_low", 32'(bus1.hsync), 32'd0);
                check("vs_first_low", 32'(bus1.vsync), 32'd0);
                check("hs2_n2", 32'(bus2.hsync), 32'd1);
      adv(3);   check("hs2_first_low", 32'(bus2.hsync), 32'd0);
      adv(5);   check("hs_last_low", 32'(bus1.hsync), 32'd0);
      adv(6);   check("hs_rise", 32'(bus1.hsync), 32'd1);
      adv(10);  check("hs2_last_low", 32'(bus2.hsync), 32'd0);
      adv(11);  check("hs2_rise", 32'(bus2.hsync), 32'd1);
      adv(29);  check("hs_line_end", 32'(bus1.hsync), 32'd1);
      adv(30);  check("hs_period", 32'(bus1.hsync), 32'd0);
      adv(57);  check("vs_last_low", 32'(bus1.vsync), 32'd0);
      adv(58);  check("vs_rise", 32'(bus1.vsync), 32'd1);
                check("hs2_line_end", 32'(bus2.hsync), 32'd1);
      adv(59);  check("hs2_period", 32'(bus2.hsync), 32'd0);
      adv(93);  check("rgb_vblank", 32'(bus1.vga_rgb), 32'd0);

      // Line y=4: x 7..10 col0, 11..14 col1, 15..18 col2, 19..22 col3.
      adv(120); check("rgb_x6", 32'(bus1.vga_rgb), 32'd0);
      adv(121); check("rgb_col0_first", 32'(bus1.vga_rgb), 32'd1);
      adv(124); check("rgb_col0_last", 32'(bus1.vga_rgb), 32'd1);
      adv(125); check("rgb_col1_first", 32'(bus1.vga_rgb), 32'd2);
      adv(129); check("rgb_col2_first", 32'(bus1.vga_rgb), 32'd3);
      adv(133); check("rgb_col3_first", 32'(bus1.vga_rgb), 32'd4);
      adv(136); check("rgb_col3_last", 32'(bus1.vga_rgb), 32'd4);
      adv(137); check("rgb_after_active", 32'(bus1.vga_rgb), 32'd0);

      // Mid-frame grid change must not reach the current frame.
      adv(200);
      for (int i = 0; i < 32; i++)
         g[i*3 +: 3] = 3'b010;
      bus1.grid_data = g;
      adv(233); check("tear_col0", 32'(bus1.vga_rgb), 32'd1);
      adv(245); check("tear_col3", 32'(bus1.vga_rgb), 32'd4);

      adv(559); check("tick_before", 32'(bus1.frame_tick), 32'd0);
      adv(560); check("tick_fire", 32'(bus1.frame_tick), 32'd1);
      adv(561); check("tick_after", 32'(bus1.frame_tick), 32'd0);
      adv(645); check("vs_frame_end", 32'(bus1.vsync), 32'd1);
      adv(646); check("vs_period", 32'(bus1.vsync), 32'd0);

      // Frame 1 shows the new all-green grid.
      adv(765); check("next_frame_col0", 32'(bus1.vga_rgb), 32'd2);
      adv(777); check("next_frame_col3", 32'(bus1.vga_rgb), 32'd2);
      adv(1200); check("last_cell", 32'(bus1.vga_rgb), 32'd2);
      adv(1204); check("tick_frame1", 32'(bus1.frame_tick), 32'd1);
      adv(1213); check("rgb_fp_line", 32'(bus1.vga_rgb), 32'd0);

      // Only row 0 of column 0 is red.
      adv(1250);
      g = '0;
      g[23:21] = 3'b100;
      bus1.grid_data = g;
      adv(1381); check("row_blank", 32'(bus1.vga_rgb), 32'd0);
      adv(1412); check("row0_col0", 32'(bus1.vga_rgb), 32'd4);
      adv(1413); check("row0_col1", 32'(bus1.vga_rgb), 32'd0);
      adv(1437); check("row0_line2", 32'(bus1.vga_rgb), 32'd4);

      // Asynchronous reset in the middle of a red pixel.
      rst = 1'b1;
      #1;
      check("async_rgb", 32'(bus1.vga_rgb), 32'd0);
      check("async_hsync", 32'(bus1.hsync), 32'd1);
      check("async_vsync", 32'(bus1.vsync), 32'd1);
      check("async_tick", 32'(bus1.frame_tick), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      n = 0;
      adv(1);   check("restart_hs_n1", 32'(bus1.hsync), 32'd1);
      adv(2);   check("restart_hs_n2", 32'(bus1.hsync), 32'd0);
      adv(149); check("restart_row0", 32'(bus1.vga_rgb), 32'd4);
      adv(177); check("restart_row1", 32'(bus1.vga_rgb), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
